// File: rtl/p2s_serializer_with_sig_pkg.sv
// Shared types, bounds and config clamps
// for the FIFO-fed serializer.
package p2s_pkg;

  localparam int MAX_W = 11;
  localparam int MAX_N = 6;
  localparam int WW = $clog2(MAX_W) + 1;
  localparam int NW = $clog2(MAX_N) + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SHIFT
  } state_t;

  function automatic int clamp_width(
    input int w,
    input int maxw
  );
    return (w == 0 || w > maxw) ? maxw : w;
  endfunction

  function automatic int clamp_loops(
    input int n,
    input int maxn
  );
    return (n == 0 || n > maxn) ? maxn : n;
  endfunction

endpackage

// File: rtl/p2s_serializer_with_sig_if.sv
// Serial valid/ready bit stream with
// first/last word markers.
interface p2s_ser_if;

  logic ser_valid;
  logic ser_ready;
  logic ser_data;
  logic ser_first;
  logic ser_last;

  modport master (
    output ser_valid,
    output ser_data,
    output ser_first,
    output ser_last,
    input  ser_ready
  );

  modport slave (
    input  ser_valid,
    input  ser_data,
    input  ser_first,
    input  ser_last,
    output ser_ready
  );

endinterface

// File: rtl/p2s_serializer_with_sig_shift_reg.sv
// Word shift register with a runtime
// W-bit window and selectable direction.
module p2s_shift_reg
  import p2s_pkg::*;
#(
  parameter int MW  = MAX_W,
  parameter int WWD = $clog2(MW) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_load,
  input  logic           i_shift,
  input  logic           i_lsb_first,
  input  logic [WWD-1:0] i_width,
  input  logic [MW-1:0]  i_data,
  output logic           o_bit
);

  logic [MW-1:0] r_sreg;
  logic [MW-1:0] w_mask;
  logic          w_msb;

  always_comb begin
    w_mask = '0;
    w_msb  = 1'b0;
    for (int i = 0; i < MW; i++) begin
      w_mask[i] = (i < int'(i_width));
      if (i == int'(i_width) - 1)
        w_msb = r_sreg[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_sreg <= '0;
    else if (i_load)
      r_sreg <= i_data & w_mask;
    else if (i_shift)
      r_sreg <= i_lsb_first
        ? (r_sreg >> 1)
        : ((r_sreg << 1) & w_mask);
  end

  assign o_bit = i_lsb_first ? r_sreg[0] : w_msb;

endmodule

// File: rtl/p2s_serializer_with_sig.sv
// Pops one FIFO word, waits out its pop
// latency, then serializes it bit by bit.
module p2s_serializer_with_sig
  import p2s_pkg::*;
#(
  parameter int max_FIFO_WIDTH = MAX_W,
  parameter int max_NUM_LOOPS  = MAX_N
) (
  input  logic clk,
  input  logic rst,
  input  logic [$clog2(max_FIFO_WIDTH):0] sig_FIFO_WIDTH,
  input  logic [$clog2(max_NUM_LOOPS):0]  sig_NUM_LOOPS,
  input  logic sig_LSB_FIRST,
  input  logic empty,
  output logic pop,
  input  logic [max_FIFO_WIDTH-1:0] pop_data,
  p2s_ser_if.master ser,
  output logic busy
);

  localparam int CW = $clog2(max_FIFO_WIDTH) + 1;
  localparam int CN = $clog2(max_NUM_LOOPS) + 1;

  state_t        r_state;
  state_t        w_state;
  logic [CW-1:0] r_w;
  logic [CW-1:0] r_bit_cnt;
  logic [CN-1:0] r_lat_cnt;
  logic          r_lsb;
  logic [CW-1:0] w_w;
  logic [CN-1:0] w_n;
  logic          w_load;
  logic          w_shift;
  logic          w_valid;
  logic          w_bit;

  assign w_w = CW'(clamp_width(
    int'(sig_FIFO_WIDTH), max_FIFO_WIDTH));
  assign w_n = CN'(clamp_loops(
    int'(sig_NUM_LOOPS), max_NUM_LOOPS));

  assign w_valid = (r_state == SHIFT);

  always_comb begin
    w_state = r_state;
    pop     = 1'b0;
    w_load  = 1'b0;
    w_shift = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!empty && !rst) begin
          pop     = 1'b1;
          w_state = WAIT;
        end
      end
      WAIT: begin
        if (r_lat_cnt == CN'(1)) begin
          w_load  = 1'b1;
          w_state = SHIFT;
        end
      end
      SHIFT: begin
        if (ser.ser_ready) begin
          w_shift = 1'b1;
          if (r_bit_cnt == CW'(1))
            w_state = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_w       <= '0;
      r_bit_cnt <= '0;
      r_lat_cnt <= '0;
      r_lsb     <= 1'b0;
    end else begin
      r_state <= w_state;
      if (pop) begin
        r_w       <= w_w;
        r_lsb     <= sig_LSB_FIRST;
        r_lat_cnt <= w_n;
      end else if (r_state == WAIT) begin
        r_lat_cnt <= r_lat_cnt - CN'(1);
      end
      if (w_load)
        r_bit_cnt <= r_w;
      else if (w_shift)
        r_bit_cnt <= r_bit_cnt - CW'(1);
    end
  end

  p2s_shift_reg #(
    .MW  (max_FIFO_WIDTH),
    .WWD (CW)
  ) u_sreg (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_shift     (w_shift),
    .i_lsb_first (r_lsb),
    .i_width     (r_w),
    .i_data      (pop_data),
    .o_bit       (w_bit)
  );

  assign ser.ser_valid = w_valid;
  assign ser.ser_data  = w_valid & w_bit;
  assign ser.ser_first = w_valid & (r_bit_cnt == r_w);
  assign ser.ser_last  = w_valid & (r_bit_cnt == CW'(1));
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_p2s_serializer_with_sig.sv
// Directed bench with a word-level model
// of the FIFO and expected bit stream.
module tb_p2s_serializer_with_sig;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  sig_w;
  logic [3:0]  sig_n;
  logic        lsb;
  logic        empty;
  logic        pop;
  logic [10:0] pop_data;
  logic        busy;

  p2s_ser_if s_if ();

  p2s_serializer_with_sig dut (
    .clk            (clk),
    .rst            (rst),
    .sig_FIFO_WIDTH (sig_w),
    .sig_NUM_LOOPS  (sig_n),
    .sig_LSB_FIRST  (lsb),
    .empty          (empty),
    .pop            (pop),
    .pop_data       (pop_data),
    .ser            (s_if),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;

  logic [10:0] fifo_q[$];
  bit          force_empty = 0;
  int          rdy_mode = 0;
  int          rcnt = 0;
  logic [10:0] pend_word = '0;
  int          pend_cyc = -1;

  bit m_busy = 0;
  int m_start = 0;
  int m_idx = 0;
  int m_w = 0;
  int m_pop_cyc = 0;
  bit m_bits[0:15];

  int          pop_cnt = 0;
  int          cur_beats = 0;
  logic [15:0] cur_bits = '0;
  int          cur_lat = 0;
  int          log_beats[$];
  logic [15:0] log_bits[$];
  int          log_lat[$];

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO side: data is only valid on the exact
  // cycle the pop latency says; junk otherwise.
  always @(posedge clk) begin
    #2;
    pop_data = (cyc == pend_cyc) ? pend_word : ~pend_word;
    empty = rst || force_empty || (fifo_q.size() == 0);
    s_if.ser_ready = (rdy_mode == 0) ? 1'b1 : (rcnt % 3 == 0);
    rcnt++;
  end

  task automatic chk(string nm, logic act, logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_int(string nm, int act, int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic ev, ed, ef, el, ep;
    int wv, nv;
    logic [10:0] wd;
    if (chk_en) begin
      ep = !m_busy && !empty;
      ev = m_busy && (cyc >= m_start);
      ed = 0; ef = 0; el = 0;
      if (ev) begin
        ed = m_bits[m_idx];
        ef = (m_idx == 0);
        el = (m_idx == m_w - 1);
      end
      chk("pop", pop, ep);
      chk("busy", busy, m_busy);
      chk("ser_valid", s_if.ser_valid, ev);
      chk("ser_data", s_if.ser_data, ed);
      chk("ser_first", s_if.ser_first, ef);
      chk("ser_last", s_if.ser_last, el);
      if (rst) begin
        m_busy = 0;
        pend_cyc = -1;
        cur_beats = 0;
        cur_bits = '0;
      end else if (ev && s_if.ser_ready) begin
        if (cur_beats == 0) cur_lat = cyc - m_pop_cyc;
        cur_bits = {cur_bits[14:0], s_if.ser_data};
        cur_beats++;
        m_idx++;
        if (m_idx == m_w) begin
          m_busy = 0;
          log_beats.push_back(cur_beats);
          log_bits.push_back(cur_bits);
          log_lat.push_back(cur_lat);
          cur_beats = 0;
          cur_bits = '0;
        end
      end else if (!m_busy && pop && fifo_q.size() > 0) begin
        wd = fifo_q.pop_front();
        wv = (sig_w == 0 || sig_w > 11) ? 11 : int'(sig_w);
        nv = (sig_n == 0 || sig_n > 6) ? 6 : int'(sig_n);
        for (int i = 0; i < wv; i++)
          m_bits[i] = lsb ? wd[i] : wd[wv-1-i];
        m_w = wv;
        m_idx = 0;
        m_start = cyc + nv + 1;
        m_pop_cyc = cyc;
        pend_cyc = cyc + nv;
        pend_word = wd;
        m_busy = 1;
        pop_cnt++;
      end
    end
  end

  task automatic wait_idle(int budget, string nm);
    bit done = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (!m_busy && fifo_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    #1;
    if (!done) begin
      miscompares++;
      $display("FAIL timeout_%s cyc=%0d", nm, cyc);
    end
  endtask

  task automatic cfg(int w, int n, bit l);
    sig_w = 5'(w);
    sig_n = 4'(n);
    lsb = l;
  endtask

  initial begin
    int p0;
    bit got;
    rst = 1;
    empty = 1;
    pop_data = '0;
    s_if.ser_ready = 1;
    cfg(8, 3, 0);
    @(posedge clk);
    chk_en = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_pop", pop, 1'b0);
    chk("rst_valid", s_if.ser_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 0;

    fifo_q.push_back(11'h0A5);
    wait_idle(100, "t1");
    chk_int("t1_beats", log_beats[0], 8);
    chk_int("t1_bits", int'(log_bits[0]), 'hA5);
    chk_int("t1_lat", log_lat[0], 4);

    cfg(8, 3, 1);
    fifo_q.push_back(11'h0A5);
    wait_idle(100, "t2a");
    chk_int("t2a_bits", int'(log_bits[1]), 'hA5);
    fifo_q.push_back(11'h00F);
    wait_idle(100, "t2b");
    chk_int("t2b_bits", int'(log_bits[2]), 'hF0);

    cfg(11, 6, 0);
    rdy_mode = 1;
    fifo_q.push_back(11'h7FF);
    wait_idle(200, "t3");
    rdy_mode = 0;
    chk_int("t3_beats", log_beats[3], 11);
    chk_int("t3_bits", int'(log_bits[3]), 'h7FF);

    cfg(8, 2, 0);
    force_empty = 1;
    fifo_q.push_back(11'h03C);
    p0 = pop_cnt;
    repeat (20) @(posedge clk);
    #1;
    chk_int("t4_no_pop", pop_cnt, p0);
    force_empty = 0;
    wait_idle(100, "t4");
    chk_int("t4_one_pop", pop_cnt, p0 + 1);
    chk_int("t4_bits", int'(log_bits[4]), 'h3C);

    cfg(15, 0, 0);
    fifo_q.push_back(11'h5A3);
    fifo_q.push_back(11'h00B);
    repeat (9) @(posedge clk);
    #1;
    sig_w = 5'd4;
    wait_idle(200, "t5");
    chk_int("t5a_beats", log_beats[5], 11);
    chk_int("t5a_bits", int'(log_bits[5]), 'h5A3);
    chk_int("t5a_lat", log_lat[5], 7);
    chk_int("t5b_beats", log_beats[6], 4);
    chk_int("t5b_bits", int'(log_bits[6]), 'hB);

    cfg(8, 2, 0);
    fifo_q.push_back(11'h0C3);
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (cur_beats == 2) begin
        got = 1;
        break;
      end
    end
    #1;
    if (!got) begin
      miscompares++;
      $display("FAIL timeout_t6 cyc=%0d", cyc);
    end
    rst = 1;
    fifo_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("t6_valid", s_if.ser_valid, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_pop", pop, 1'b0);
    chk("t6_first", s_if.ser_first, 1'b0);
    chk("t6_last", s_if.ser_last, 1'b0);
    @(posedge clk); #1;
    rst = 0;
    p0 = pop_cnt;
    fifo_q.push_back(11'h081);
    wait_idle(100, "t6");
    chk_int("t6_words", log_bits.size(), 8);
    chk_int("t6_repop", pop_cnt, p0 + 1);
    chk_int("t6_bits", int'(log_bits[7]), 'h81);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
